sseg_scan: RTL and testbench

- Parametrised, time-multiplexed seven-segment driver for DIGITS common-anode/cathode digits sharing one segment bus.
- Latches a packed BCD/hex word with per-digit decimal-point and blank masks, plus a sign flag.
- Scans digits at a programmable rate and applies new data only at frame boundaries, so the display never tears.
- Sits between the gauge/readout logic and the board display pins; successor to the single-digit combinational decoder.

---
 rtl/sseg_pkg.sv | 53 +++++
 rtl/sseg_scan_if.sv | 35 +++
 rtl/sseg_glyph.sv | 28 ++
 rtl/sseg_scan.sv | 174 +++++++++++++++++
 tb/tb_sseg_scan.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared glyph constants and helpers for the seven-segment scanner.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_OFF   = 7'h00;

  // Hex nibble to active-high segment pattern.
  function automatic logic [6:0] nib_to_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Convert an active-high 8-bit segment word to the pin polarity.
  function automatic logic [7:0] apply_pol(input logic [7:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/sseg_scan_if.sv
// Data/strobe bundle between the readout logic and the seven-segment scanner.
// With SSEG_BLINK_EN defined the bundle also carries blink_mask.
interface sseg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blank_mask;
  logic                  neg;
  logic                  lz_en;
`ifdef SSEG_BLINK_EN
  logic [DIGITS-1:0]     blink_mask;
`endif
  logic [7:0]            hex;
  logic [DIGITS-1:0]     an;
  logic                  frame;
  logic                  pending;

  modport master (
    output load, value, dp_mask, blank_mask, neg, lz_en,
`ifdef SSEG_BLINK_EN
    output blink_mask,
`endif
    input  hex, an, frame, pending
  );

  modport slave (
    input  load, value, dp_mask, blank_mask, neg, lz_en,
`ifdef SSEG_BLINK_EN
    input  blink_mask,
`endif
    output hex, an, frame, pending
  );
endinterface

// File: rtl/sseg_glyph.sv
// Combinational glyph selection for the currently scanned digit.
// Output is active-high {dp,g..a}; blank beats sign beats suppression.
module sseg_glyph
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       sign,
  input  logic       blank,
  input  logic       suppress,
  output logic [7:0] seg
);

  // Priority: blank, minus sign, leading-zero suppression, hex glyph.
  always_comb begin
    seg = {1'b0, GLYPH_OFF};
    if (blank) begin
      seg = {1'b0, GLYPH_OFF};
    end else if (sign) begin
      seg = {dp, GLYPH_MINUS};
    end else if (suppress) begin
      seg = {1'b0, GLYPH_OFF};
    end else begin
      seg = {dp, nib_to_glyph(nib)};
    end
  end

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed seven-segment driver. New data is staged in a shadow
// register and promoted to the display register only at frame boundaries.
// Optional SSEG_BLINK_EN adds per-digit blinking driven by a frame counter.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic        clk,
  input  logic        reset,
  sseg_scan_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]        HEX_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  // Data word layout: {[blink_mask,] lz_en, neg, blank_mask, dp_mask, value}
`ifdef SSEG_BLINK_EN
  localparam int DW = 7*DIGITS + 2;
`else
  localparam int DW = 6*DIGITS + 2;
`endif

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     shadow_q, shadow_d, disp_q, disp_d, live_w;
  logic              pending_q, pending_d;
  logic [7:0]        hex_q, hex_d;
  logic [DIGITS-1:0] an_q, an_d, an_hot;
  logic              tick, boundary, zero_run, blink_dark;
  logic [DIGITS-1:0] supp;
  logic [7:0]        cur_seg;

  logic [4*DIGITS-1:0] disp_value;
  logic [DIGITS-1:0]   disp_dp, disp_blank;
  logic                disp_neg, disp_lz;

`ifdef SSEG_BLINK_EN
  assign live_w = {bus.blink_mask, bus.lz_en, bus.neg, bus.blank_mask, bus.dp_mask, bus.value};
`else
  assign live_w = {bus.lz_en, bus.neg, bus.blank_mask, bus.dp_mask, bus.value};
`endif

  assign disp_value = disp_q[4*DIGITS-1:0];
  assign disp_dp    = disp_q[5*DIGITS-1:4*DIGITS];
  assign disp_blank = disp_q[6*DIGITS-1:5*DIGITS];
  assign disp_neg   = disp_q[6*DIGITS];
  assign disp_lz    = disp_q[6*DIGITS+1];

  assign tick     = (div_q == DIV_LAST);
  assign boundary = tick && (idx_q == LAST_IDX);

  // Leading-zero scan from the top digit down; the sign slot is skipped when neg.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!((i == DIGITS - 1) && disp_neg)) begin
        if (disp_value[4*i +: 4] == 4'h0) begin
          supp[i] = zero_run && disp_lz;
        end else begin
          zero_run = 1'b0;
        end
      end
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  // Count frames and flip the blink phase every BLINK_FRAMES frames.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (boundary) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink phase register; phase starts "on" after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blink_dark = blink_off_q && disp_q[6*DIGITS + 2 + 32'(idx_q)];
`else
  assign blink_dark = 1'b0;
`endif

  sseg_glyph u_glyph (
    .nib      (disp_value[4*idx_q +: 4]),
    .dp       (disp_dp[idx_q]),
    .sign     (disp_neg && (idx_q == LAST_IDX)),
    .blank    (disp_blank[idx_q] || blink_dark),
    .suppress (supp[idx_q]),
    .seg      (cur_seg)
  );

  // Scan counters, shadow/display handoff and registered pin values.
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (bus.load) begin
      shadow_d = live_w;
    end
    if (boundary) begin
      // A load landing on the boundary itself goes straight to the display.
      if (bus.load) begin
        disp_d = live_w;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
    an_hot = DIGITS'(1) << idx_q;
    an_d   = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    hex_d  = apply_pol(cur_seg, SEG_ACTIVE_LOW != 0);
  end

  // State and output registers; reset forces the display dark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      hex_q     <= HEX_OFF;
      an_q      <= AN_OFF;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      hex_q     <= hex_d;
      an_q      <= an_d;
    end
  end

  assign bus.hex     = hex_q;
  assign bus.an      = an_q;
  assign bus.pending = pending_q;
  assign bus.frame   = boundary;

endmodule

// File: tb/tb_sseg_scan.sv
// Self-checking bench for sseg_scan: DIGITS=4, SCAN_DIV=4, active-low pins.
// A frame-level reference model predicts every output each cycle.
module tb_sseg_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_scan_if #(.DIGITS(DIGITS)) bus ();

  sseg_scan #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

`ifdef SSEG_BLINK_EN
  initial bus.blink_mask = '0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         n;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, s_dp, m_blank, s_blank;
  logic        m_neg, s_neg, m_lz, s_lz, m_pend;
  logic [7:0]  e_hex;
  logic [3:0]  e_an;

  logic [6:0] gtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Active-low pin value a digit should show, from the display contents.
  function automatic logic [7:0] ref_seg(input int d);
    logic [3:0] nib;
    bit hi_zero;
    nib = m_val[4*d +: 4];
    if (m_blank[d]) return 8'hFF;
    if (d == DIGITS - 1 && m_neg) return ~{m_dp[d], 7'h40};
    if (m_lz && nib == 4'h0 && d != 0) begin
      hi_zero = 1'b1;
      for (int j = d + 1; j < DIGITS; j++)
        if (!(j == DIGITS - 1 && m_neg) && m_val[4*j +: 4] != 4'h0) hi_zero = 1'b0;
      if (hi_zero) return 8'hFF;
    end
    return ~{m_dp[d], gtab[nib]};
  endfunction

  task automatic model_reset();
    n = 0;
    m_val = '0; s_val = '0; m_dp = '0; s_dp = '0; m_blank = '0; s_blank = '0;
    m_neg = 0; s_neg = 0; m_lz = 0; s_lz = 0; m_pend = 0;
    e_hex = 8'hFF; e_an = 4'hF;
  endtask

  // One clock: advance model with the inputs present at the edge, then compare.
  task automatic cyc();
    logic ld, c_neg, c_lz;
    logic [15:0] c_val;
    logic [3:0] c_dp, c_blank;
    int idx;
    bit bnd;
    ld = bus.load; c_val = bus.value; c_dp = bus.dp_mask; c_blank = bus.blank_mask;
    c_neg = bus.neg; c_lz = bus.lz_en;
    @(posedge clk);
    idx = (n / SCAN_DIV) % DIGITS;
    e_an = ~(4'b0001 << idx);
    e_hex = ref_seg(idx);
    bnd = (n % FRAME) == FRAME - 1;
    if (bnd) begin
      if (ld) begin
        m_val = c_val; m_dp = c_dp; m_blank = c_blank; m_neg = c_neg; m_lz = c_lz;
      end else if (m_pend) begin
        m_val = s_val; m_dp = s_dp; m_blank = s_blank; m_neg = s_neg; m_lz = s_lz;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      s_val = c_val; s_dp = c_dp; s_blank = c_blank; s_neg = c_neg; s_lz = c_lz;
      m_pend = 1'b1;
    end
    n++;
    #1;
    chk("hex", 32'(bus.hex), 32'(e_hex));
    chk("an", 32'(bus.an), 32'(e_an));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("frame", 32'(bus.frame), 32'((n % FRAME) == FRAME - 1));
    $display("cyc %0d: an=%b hex=%h pending=%b frame=%b", n, bus.an, bus.hex, bus.pending, bus.frame);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blank,
                         input logic ng, input logic lz);
    bus.value = v; bus.dp_mask = dp; bus.blank_mask = blank; bus.neg = ng; bus.lz_en = lz;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  // Run until the cycle right after a frame boundary.
  task automatic to_boundary();
    do cyc(); while (n % FRAME != 0);
  endtask

  // Run until digit d is lit, then compare its pins against a fixed pattern.
  task automatic see_digit(input int d, input logic [7:0] want, input string tag);
    logic [3:0] want_an;
    want_an = ~(4'b0001 << d);
    for (int k = 0; k < FRAME; k++) begin
      cyc();
      if (bus.an === want_an) break;
    end
    chk({tag, "_an"}, 32'(bus.an), 32'(want_an));
    chk(tag, 32'(bus.hex), 32'(want));
  endtask

  initial begin
    bus.load = 0; bus.value = '0; bus.dp_mask = '0; bus.blank_mask = '0;
    bus.neg = 0; bus.lz_en = 0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hex", 32'(bus.hex), 32'hFF);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_frame", 32'(bus.frame), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (40) cyc();

    // Mid-frame load: held pending until the boundary.
    while (n % FRAME != 6) cyc();
    do_load(16'h12AF, 4'b0100, 4'b0000, 1'b0, 1'b0);
    chk("pend_after_load", 32'(bus.pending), 32'h1);
    see_digit(0, 8'h8E, "d0_F");
    see_digit(1, 8'h88, "d1_A");
    see_digit(2, 8'h24, "d2_2dp");
    see_digit(3, 8'hF9, "d3_1");

    // Leading-zero suppression, then with the sign digit.
    do_load(16'h0007, 4'b0000, 4'b0000, 1'b0, 1'b1);
    to_boundary();
    see_digit(0, 8'hF8, "lz_d0");
    see_digit(1, 8'hFF, "lz_d1");
    see_digit(2, 8'hFF, "lz_d2");
    see_digit(3, 8'hFF, "lz_d3");
    do_load(16'h0007, 4'b0000, 4'b0000, 1'b1, 1'b1);
    to_boundary();
    see_digit(0, 8'hF8, "neg_d0");
    see_digit(1, 8'hFF, "neg_d1");
    see_digit(2, 8'hFF, "neg_d2");
    see_digit(3, 8'hBF, "neg_d3");

    // Blank mask.
    do_load(16'h8888, 4'b0000, 4'b0001, 1'b0, 1'b0);
    to_boundary();
    see_digit(0, 8'hFF, "blk_d0");
    see_digit(1, 8'h80, "blk_d1");
    see_digit(3, 8'h80, "blk_d3");

    // Load exactly on the boundary cycle: bypasses, pending never rises.
    while (n % FRAME != FRAME - 1) cyc();
    do_load(16'h4321, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("bnd_pending", 32'(bus.pending), 32'h0);
    see_digit(0, 8'hF9, "bnd_d0");
    see_digit(3, 8'h99, "bnd_d3");

    // Two loads in one frame: last write wins.
    to_boundary();
    repeat (2) cyc();
    do_load(16'h5555, 4'b1111, 4'b0000, 1'b0, 1'b0);
    repeat (3) cyc();
    do_load(16'h9876, 4'b0000, 4'b0000, 1'b0, 1'b0);
    to_boundary();
    see_digit(0, 8'h82, "two_d0");
    see_digit(3, 8'h90, "two_d3");

    // Async reset mid-digit: dark with no clock edge, shadow lost.
    repeat (5) cyc();
    do_load(16'hABCD, 4'b0000, 4'b0000, 1'b0, 1'b0);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_hex", 32'(bus.hex), 32'hFF);
    chk("arst_an", 32'(bus.an), 32'hF);
    chk("arst_pending", 32'(bus.pending), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (20) cyc();

    // Randomized loads at random points, including boundaries.
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(7) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom_range(3) == 0 ? $urandom : 0),
                1'($urandom), 1'($urandom));
      else
        cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
